// File: rtl/uart_encoder.sv
// uart_encoder: byte-stream to 8N1 serial transmitter with a small input FIFO.
//
// Bytes offered on data_i/valid_i are queued in a circular FIFO and shifted
// out LSB first as start / 8 data / stop frames, each bit lasting CLKS_PER_BIT
// clocks. When a stop bit ends with more bytes queued, the next start bit
// follows immediately, so streamed bytes leave with no idle gap.
//
// Optional build macro UART_ENCODER_PARITY_EN adds a parity bit between the
// last data bit and the stop bit, plus the parity_odd_i select input.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset (abandons frame, drops queue)
//   parity_odd_i 0 = even, 1 = odd parity; sampled at pop (parity build only)
//   data_i       byte to queue
//   valid_i      data_i is valid; accepted when ready_o is high
//   ready_o      FIFO has room
//   tx_o         serial line, idle high
//   busy_o       frame in flight or bytes queued
//   level_o      FIFO occupancy, 0..2**FIFO_AW
module uart_encoder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef UART_ENCODER_PARITY_EN
  input  logic               parity_odd_i,
`endif
  input  logic [7:0]         data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_ENCODER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q,  state_d;
  logic [BW-1:0]        baud_q,   baud_d;
  logic [2:0]           bit_q,    bit_d;
  logic [7:0]           shift_q,  shift_d;
  logic                 tx_q,     tx_d;
  logic                 busy_q,   busy_d;
  logic [FIFO_AW:0]     level_q,  level_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
`ifdef UART_ENCODER_PARITY_EN
  logic                 par_q,    par_d;
`endif

  logic push, pop, baud_end;

  assign ready_o = (level_q != LVL_FULL);
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign level_o = level_q;

  always_comb begin
    push     = valid_i && ready_o;
    baud_end = (baud_q == BAUD_LAST);
    pop      = 1'b0;
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    baud_d   = baud_end ? '0 : baud_q + BAUD_ONE;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    level_d  = level_q;
`ifdef UART_ENCODER_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_ENCODER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_ENCODER_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more bytes are queued.
        if (baud_end) begin
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef UART_ENCODER_PARITY_EN
      par_d    = (^mem_q[rd_ptr_q]) ^ parity_odd_i;
`endif
    end

    if (push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (!push && pop) level_d = level_q - LVL_ONE;

    // Line value follows the current state, so it lags the state register
    // by one clock: a byte popped on edge E+1 drives the start bit from E+2.
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART_ENCODER_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_ENCODER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
`ifdef UART_ENCODER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_encoder.md
Name: uart_encoder

Overview:
- Byte-stream-to-serial UART transmitter. It is the drive-side counterpart of the bench UART decoder.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on a single line.
- Used in orpsoc_tb to feed uart0_srx_pad_i, so console input and boot scripts can be injected into the SoC.
- Fully synthesizable, so it can also be reused as an on-chip loopback or test source.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit. 434 gives 115200 baud at 50 MHz. Legal range is 2 and above.
- FIFO_AW, 4: FIFO address width. Depth is 2**FIFO_AW = 16 bytes.

Ports:
- clk_i  input  1: system clock; all logic is on the rising edge.
- rst_i  input  1: reset, synchronous and active-high.
- data_i  input  8: byte to transmit.
- valid_i  input  1: data_i is valid.
- ready_o  output  1: FIFO can accept a byte.
- tx_o  output  1: serial line, idle high.
- busy_o  output  1: a frame is in progress or the FIFO is non-empty.
- level_o  output  FIFO_AW+1: current FIFO occupancy, 0..2**FIFO_AW.

Behaviour:
- Reset values (sampled on the clock edge while rst_i=1):
  - tx_o=1, ready_o=1, busy_o=0, level_o=0.
  - FIFO pointers cleared, state=IDLE, bit and baud counters cleared.
- Reset mid-frame: the frame is abandoned. tx_o returns high on the next edge and all queued bytes are discarded.
- Input handshake: a byte is pushed on an edge where valid_i=1 and ready_o=1.
  - ready_o = (level_o != 2**FIFO_AW). It is combinational from the registered level.
  - When the FIFO is full, valid_i is ignored and data_i does not change FIFO contents.
- FIFO: circular buffer; pointers wrap modulo 2**FIFO_AW.
  - level_o increments on a push only and decrements on a pop only.
  - Simultaneous push and pop leaves level_o unchanged.
- State machine (all outputs registered):
  - IDLE: tx_o=1. If the FIFO is non-empty: pop the head byte into the shift register, clear the baud counter and go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] (LSB first) for CLKS_PER_BIT cycles, then shift right.
    - After bit 7, go to STOP (or PARITY, see Optional Feature).
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
    - If the FIFO is non-empty, pop and go directly to START. There is no idle gap between frames.
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. A bit period ends at terminal count, then the counter reloads to 0.
  - Width is clog2(CLKS_PER_BIT).
- Frame length: exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Latency: for a byte pushed on edge E into an empty FIFO with state IDLE:
  - The pop occurs on edge E+1.
  - tx_o is low from edge E+2 onward.
- busy_o = (state != IDLE) or (level_o != 0), registered.
  - It deasserts on the edge where STOP completes with an empty FIFO.
- A push arriving in the same cycle the FIFO becomes empty from a pop is accepted normally.
  - That byte is sent in the next frame, or after one IDLE cycle if STOP has already completed.

Optional Feature:
- Macro: UART_ENCODER_PARITY_EN.
- Defined:
  - Adds input port parity_odd_i (1 bit, sampled when each byte is popped).
  - After DATA bit 7 the state machine enters PARITY for CLKS_PER_BIT cycles, then STOP.
  - Parity value is ^data XOR parity_odd_i: even parity when 0, odd parity when 1.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_odd_i port; frames are 8N1 only.

Test Plan:
- Reset/idle: hold rst_i 3 cycles, release → tx_o=1, ready_o=1, busy_o=0, level_o=0 with no activity for 100 cycles.
- Single byte: CLKS_PER_BIT=4, push 0xA5 on edge E → tx_o low from E+2. Each bit lasts 4 cycles. Line sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy_o=0 after 40 cycles.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles → three frames with no idle cycles between the stop bit and the next start bit. The bench decoder reports 0x00, 0xFF, 0x55.
- Full/overflow: hold valid_i with bytes 0x01..0x14 while a frame is in progress → level_o reaches 16 and ready_o drops. Only accepted bytes are transmitted, in order, with no duplicates or losses.
- Reset mid-frame: assert rst_i during DATA bit 3 of 0x3C with 5 bytes queued → tx_o=1 and level_o=0 on the next edge. No further frames are sent.
- Parity (UART_ENCODER_PARITY_EN defined): send 0x07 with parity_odd_i=0 → parity bit 1. Send with parity_odd_i=1 → parity bit 0. Frame length is 44 cycles at CLKS_PER_BIT=4.
